// File: rtl/expand_s.sv
// ML-DSA ExpandS (eta=2): rejection-samples SHAKE256 nibbles into packed 24-bit coefficients for s1/s2.
// Write lands 1 cycle after the 4th coefficient; sponge stalls on in_ready/out_valid just hold the FSM.
module expand_s #(
    parameter int SEED_SIZE             = 512,
    parameter int REJ_BOUNDED_POLY_SEED = 528,
    parameter int WORD_LEN              = 96,
    parameter int K                     = 8,
    parameter int L                     = 7,
    parameter int N                     = 256,
    parameter int ETA                   = 2,
    parameter int COEFF_WIDTH           = 24,
    parameter int DATA_IN_BITS          = 64,
    parameter int DATA_OUT_BITS         = 64,
    parameter int ADDR_WIDTH            = 4,
    parameter int DATA_WIDTH            = 64,
    parameter int COEFF_PER_WORD        = WORD_LEN / COEFF_WIDTH,
    parameter int ADDR_POLY_WIDTH       = $clog2((L + K) * N * COEFF_WIDTH / WORD_LEN)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [SEED_SIZE-1:0]       rho,
    output logic                       done,
    output logic                       we_vector_s,
    output logic [ADDR_POLY_WIDTH-1:0] addr_vector_s,
    output logic [WORD_LEN-1:0]        din_vector_s,
    output logic                       absorb_next_poly,
    output logic [DATA_IN_BITS-1:0]    shake_data_in,
    output logic                       in_valid,
    input  logic                       in_ready,
    output logic                       in_last,
    output logic [6:0]                 last_len,
    output logic                       out_ready,
    input  logic                       out_valid,
    input  logic [DATA_OUT_BITS-1:0]   shake_data_out
);
    localparam int ABS_WORDS = (REJ_BOUNDED_POLY_SEED + DATA_IN_BITS - 1) / DATA_IN_BITS;
    localparam int WC_W      = $clog2(ABS_WORDS);
    localparam int R_W       = $clog2(L + K);
    localparam int C_W       = $clog2(N + 1);
    localparam int S_W       = $clog2(COEFF_PER_WORD);
    localparam int NIBBLES   = DATA_WIDTH / 4;

    typedef enum logic [2:0] {
        IDLE, SPONGE_RST, ABSORB, SQUEEZE, SAMPLE, NEXT, DONE
    } state_t;

    state_t                   state, state_n;
    logic [SEED_SIZE-1:0]     rho_q;
    logic [R_W-1:0]           r;
    logic [WC_W-1:0]          word_cnt;
    logic [C_W-1:0]           ccnt;
    logic [ADDR_WIDTH-1:0]    nib;
    logic [DATA_WIDTH-1:0]    sq_word;
    logic [WORD_LEN-1:0]      coef_buf, buf_n;
    logic [3:0]               nib_val;
    logic [COEFF_WIDTH-1:0]   coef;
    logic [S_W-1:0]           slot;
    logic                     accept, poly_full;

    assign nib_val   = sq_word[4*nib +: 4];
    // Nibble 15 is the only reject value for eta=2; the rest map to eta - (b mod 5).
    assign coef      = COEFF_WIDTH'(ETA) - COEFF_WIDTH'(nib_val % (2 * ETA + 1));
    assign slot      = ccnt[S_W-1:0];
    assign accept    = (state == SAMPLE) && (nib_val != 4'hF);
    assign poly_full = accept && (ccnt == C_W'(N - 1));

    always_comb begin
        buf_n = coef_buf;
        buf_n[COEFF_WIDTH*slot +: COEFF_WIDTH] = coef;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n          = state;
        done             = 1'b0;
        absorb_next_poly = 1'b0;
        in_valid         = 1'b0;
        in_last          = 1'b0;
        last_len         = '0;
        out_ready        = 1'b0;
        shake_data_in    = '0;
        case (state)
            IDLE: if (start) state_n = SPONGE_RST;
            SPONGE_RST: begin
                absorb_next_poly = 1'b1;
                state_n          = ABSORB;
            end
            ABSORB: begin
                in_valid = 1'b1;
                if (word_cnt == WC_W'(ABS_WORDS - 1)) begin
                    in_last       = 1'b1;
                    last_len      = 7'(REJ_BOUNDED_POLY_SEED - SEED_SIZE);
                    shake_data_in = DATA_IN_BITS'(r);
                    if (in_ready) state_n = SQUEEZE;
                end else begin
                    shake_data_in = rho_q[DATA_IN_BITS*word_cnt +: DATA_IN_BITS];
                end
            end
            SQUEEZE: begin
                out_ready = 1'b1;
                if (out_valid) state_n = SAMPLE;
            end
            SAMPLE: begin
                if (poly_full)                               state_n = NEXT;
                else if (nib == ADDR_WIDTH'(NIBBLES - 1))    state_n = SQUEEZE;
            end
            NEXT: state_n = (r == R_W'(L + K - 1)) ? DONE : SPONGE_RST;
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rho_q         <= '0;
            r             <= '0;
            word_cnt      <= '0;
            ccnt          <= '0;
            nib           <= '0;
            sq_word       <= '0;
            coef_buf      <= '0;
            we_vector_s   <= 1'b0;
            addr_vector_s <= '0;
            din_vector_s  <= '0;
        end else begin
            we_vector_s <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    rho_q <= rho;
                    r     <= '0;
                end
                SPONGE_RST: begin
                    ccnt     <= '0;
                    word_cnt <= '0;
                end
                ABSORB: if (in_ready) word_cnt <= word_cnt + 1'b1;
                SQUEEZE: if (out_valid) begin
                    sq_word <= shake_data_out;
                    nib     <= '0;
                end
                SAMPLE: begin
                    nib <= nib + 1'b1;
                    if (accept) begin
                        coef_buf <= buf_n;
                        ccnt     <= ccnt + 1'b1;
                        if (slot == S_W'(COEFF_PER_WORD - 1)) begin
                            we_vector_s   <= 1'b1;
                            addr_vector_s <= ADDR_POLY_WIDTH'(r) * ADDR_POLY_WIDTH'(N / COEFF_PER_WORD)
                                           + ADDR_POLY_WIDTH'(ccnt / C_W'(COEFF_PER_WORD));
                            din_vector_s  <= buf_n;
                        end
                    end
                end
                NEXT: r <= r + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_expand_s.sv
// Bench for expand_s: sponge stub plus scoreboard of expected RAM writes.
module tb_expand_s;
    localparam logic [511:0] GOLD = {8{64'h1234567890abcdef}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [511:0] rho = '0;
    logic         done, we_vector_s, absorb_next_poly, in_valid, in_last, out_ready;
    logic [9:0]   addr_vector_s;
    logic [95:0]  din_vector_s;
    logic [63:0]  shake_data_in;
    logic [6:0]   last_len;
    logic         in_ready = 1'b0;
    logic         out_valid = 1'b0;
    logic [63:0]  shake_data_out = '0;

    expand_s dut (
        .clk(clk), .rst(rst), .start(start), .rho(rho), .done(done),
        .we_vector_s(we_vector_s), .addr_vector_s(addr_vector_s), .din_vector_s(din_vector_s),
        .absorb_next_poly(absorb_next_poly), .shake_data_in(shake_data_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .last_len(last_len),
        .out_ready(out_ready), .out_valid(out_valid), .shake_data_out(shake_data_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mix(input logic [63:0] x);
        logic [63:0] z;
        z = x + 64'h9E3779B97F4A7C15;
        z = (z ^ (z >> 30)) * 64'hBF58476D1CE4E5B9;
        z = (z ^ (z >> 27)) * 64'h94D049BB133111EB;
        return z ^ (z >> 31);
    endfunction

    int coef_tab [15] = '{2, 1, 0, -1, -2, 2, 1, 0, -1, -2, 2, 1, 0, -1, -2};

    logic [511:0] exp_rho;
    logic [105:0] sb [$];
    logic [95:0]  img [960];
    logic [95:0]  img_ref [960];
    logic [63:0]  h;
    logic [95:0]  m_buf;
    int poly_idx, abs_k, sq_k, m_cnt, wr_cnt, done_cnt, cyc, last_wr_cyc, done_cyc;
    bit stall, first_sq;

    // Poly 0's first squeeze word exercises the reject / +2 / -1 / -2 nibble cases.
    function automatic logic [63:0] gen_word();
        if (poly_idx == 0 && sq_k == 0) return 64'h0000_0000_E943_FFFF;
        return mix(h + 64'(sq_k) * 64'hD1B54A32D192ED03);
    endfunction

    initial begin : monitor
        logic [63:0]        w;
        logic [3:0]         v;
        logic [105:0]       e;
        logic signed [23:0] sv;
        bit                 ok;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            in_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            out_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (absorb_next_poly && !rst) begin
                poly_idx++;
                h = '0; sq_k = 0; abs_k = 0; m_cnt = 0; first_sq = 1;
            end
            if (in_valid && in_ready && !rst) begin
                check("abs_dat", shake_data_in, (abs_k < 8) ? exp_rho[64*abs_k +: 64] : 64'(poly_idx));
                check("abs_last", in_last, abs_k == 8);
                if (abs_k == 8) check("abs_len", last_len, 16);
                h = mix(h ^ shake_data_in);
                abs_k++;
            end
            shake_data_out = gen_word();
            if (out_ready && out_valid && !rst) begin
                if (first_sq) begin
                    check("abs_words", abs_k, 9);
                    first_sq = 0;
                end
                w = shake_data_out;
                for (int b = 0; b < 16; b++) begin
                    v = w[4*b +: 4];
                    if (v != 4'hF && m_cnt < 256) begin
                        m_buf[24*(m_cnt%4) +: 24] = 24'(coef_tab[v]);
                        m_cnt++;
                        if (m_cnt % 4 == 0)
                            sb.push_back({10'(poly_idx*64 + (m_cnt-1)/4), m_buf});
                    end
                end
                sq_k++;
            end
            if (we_vector_s) begin
                check("sb_occupancy", sb.size() == 0, 0);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("wr_addr", addr_vector_s, e[105:96]);
                    check("wr_din", din_vector_s, e[95:0]);
                end
                ok = 1;
                for (int s = 0; s < 4; s++) begin
                    sv = din_vector_s[24*s +: 24];
                    if (sv < -2 || sv > 2) ok = 0;
                end
                check("coef_range", ok, 1);
                if (wr_cnt == 0) check("nib_map0", din_vector_s, 96'hFFFFFE_FFFFFE_FFFFFE_FFFFFF);
                if (wr_cnt == 1) check("nib_map1", din_vector_s, 96'h000002_000002_000002_000002);
                if (addr_vector_s < 960) img[addr_vector_s] = din_vector_s;
                wr_cnt++;
                last_wr_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check_idle_outputs();
        check("rst_done", done, 0);
        check("rst_we", we_vector_s, 0);
        check("rst_addr", addr_vector_s, 0);
        check("rst_din", din_vector_s, 0);
        check("rst_anp", absorb_next_poly, 0);
        check("rst_in_valid", in_valid, 0);
        check("rst_in_last", in_last, 0);
        check("rst_last_len", last_len, 0);
        check("rst_out_ready", out_ready, 0);
        check("rst_sdi", shake_data_in, 0);
    endtask

    task automatic begin_run(input bit stl);
        sb.delete();
        poly_idx = -1; abs_k = 0; sq_k = 0; m_cnt = 0; wr_cnt = 0; done_cnt = 0;
        last_wr_cyc = 0; done_cyc = 0; h = '0; first_sq = 0; stall = stl;
        exp_rho = GOLD;
        for (int i = 0; i < 960; i++) img[i] = '0;
    endtask

    task automatic pulse_start(input logic [511:0] val);
        @(posedge clk); #1;
        rho = val; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_full(input bit stl, input int repulse_at);
        int  t;
        bit  pulsed;
        t = 0; pulsed = 0;
        begin_run(stl);
        pulse_start(GOLD);
        while (done_cnt == 0 && t < 30000) begin
            @(posedge clk); #1;
            t++;
            if (repulse_at > 0 && !pulsed && wr_cnt >= repulse_at) begin
                pulsed = 1;
                rho = ~GOLD; start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        check("done_timeout", t < 30000, 1);
        if (repulse_at > 0) check("repulse_hit", pulsed, 1);
        repeat (20) @(posedge clk);
        #1;
        check("wr_count", wr_cnt, 960);
        check("done_count", done_cnt, 1);
        check("poly_count", poly_idx + 1, 15);
        check("done_after_wr", done_cyc > last_wr_cyc, 1);
        check("sb_left", sb.size(), 0);
    endtask

    task automatic compare_image(input string tag);
        int diffs;
        diffs = 0;
        for (int i = 0; i < 960; i++) if (img[i] !== img_ref[i]) diffs++;
        check(tag, diffs, 0);
    endtask

    initial begin : main
        int t;
        begin_run(0);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_idle_outputs();
        @(posedge clk); #1;
        rst = 1'b0;

        run_full(0, 0);
        for (int i = 0; i < 960; i++) img_ref[i] = img[i];

        run_full(1, 0);
        compare_image("image_stall");

        run_full(1, 100);
        compare_image("image_repulse");

        begin_run(1);
        pulse_start(GOLD);
        t = 0;
        while (wr_cnt < 300 && t < 30000) begin
            @(posedge clk); #1;
            t++;
        end
        check("abort_reach", wr_cnt >= 300, 1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs();
        check("abort_no_done", done_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_full(1, 0);
        compare_image("image_after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
